// File: rtl/vga_timing_core.sv
// Parametrised VGA raster timing generator with a programmable pixel-tick divider,
// pixel-source latency compensation and frame-aligned start/stop.
module vga_timing_core #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CLK_DIV  = 2,
   parameter int PIX_LAT  = 1,
   parameter int COLOR_W  = 10,
   parameter int CNT_W    = 11
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               enable,
   input  logic [COLOR_W-1:0] pix_r,
   input  logic [COLOR_W-1:0] pix_g,
   input  logic [COLOR_W-1:0] pix_b,
   output logic [CNT_W-1:0]   x_addr,
   output logic [CNT_W-1:0]   y_addr,
   output logic               addr_valid,
   output logic               pix_ce,
   output logic               line_start,
   output logic               frame_start,
   output logic               running,
   output logic [COLOR_W-1:0] vga_r_DAC,
   output logic [COLOR_W-1:0] vga_g_DAC,
   output logic [COLOR_W-1:0] vga_b_DAC,
   output logic               vga_hs,
   output logic               vga_vs,
   output logic               vga_blank
);

   // One extra bit so a total of exactly 2^CNT_W still compares correctly.
   localparam logic [CNT_W:0] H_ACT_END = (CNT_W+1)'(H_ACTIVE);
   localparam logic [CNT_W:0] HS_BEG    = (CNT_W+1)'(H_ACTIVE + H_FP);
   localparam logic [CNT_W:0] HS_END    = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W:0] H_LAST    = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [CNT_W:0] V_ACT_END = (CNT_W+1)'(V_ACTIVE);
   localparam logic [CNT_W:0] VS_BEG    = (CNT_W+1)'(V_ACTIVE + V_FP);
   localparam logic [CNT_W:0] VS_END    = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W:0] V_LAST    = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam int             DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t           state;
   logic [DIV_W-1:0] div;
   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic [CNT_W:0]   h_ext;
   logic [CNT_W:0]   v_ext;
   logic             h_last;
   logic             v_last;
   logic             de;
   logic             hs_act;
   logic             vs_act;
   logic             stop;
   logic             hold;
   logic [2:0]       tap;

   assign h_ext   = {1'b0, h_cnt};
   assign v_ext   = {1'b0, v_cnt};
   assign h_last  = (h_ext == H_LAST);
   assign v_last  = (v_ext == V_LAST);
   assign running = (state != IDLE);
   assign pix_ce  = running && (div == DIV_LAST);

   assign de     = running && (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
   assign hs_act = running && (h_ext >= HS_BEG) && (h_ext < HS_END);
   assign vs_act = running && (v_ext >= VS_BEG) && (v_ext < VS_END);

   assign x_addr      = de ? h_cnt : '0;
   assign y_addr      = de ? v_cnt : '0;
   assign addr_valid  = de;
   assign line_start  = pix_ce && (h_cnt == '0);
   assign frame_start = pix_ce && (h_cnt == '0) && (v_cnt == '0);

   // The final tick of a draining frame clears everything so IDLE begins clean.
   assign stop = (state == DRAIN) && !enable && pix_ce && h_last && v_last;
   assign hold = (state == IDLE) || stop;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (enable) state <= RUN;
            RUN:     if (!enable) state <= DRAIN;
            DRAIN: begin
               if (enable)    state <= RUN;
               else if (stop) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n || hold) begin
         div   <= '0;
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         div <= pix_ce ? '0 : div + 1'b1;
         if (pix_ce) begin
            if (h_last) begin
               h_cnt <= '0;
               v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
               h_cnt <= h_cnt + 1'b1;
            end
         end
      end
   end

   // Decode delay line: {de, hs_act, vs_act} follows the pixel source by PIX_LAT ticks.
   if (PIX_LAT == 0) begin : g_no_delay
      assign tap = {de, hs_act, vs_act};
   end else begin : g_delay
      logic [2:0] stage [PIX_LAT];

      always_ff @(posedge clock) begin
         if (!reset_n || hold) begin
            for (int i = 0; i < PIX_LAT; i++) stage[i] <= '0;
         end else if (pix_ce) begin
            stage[0] <= {de, hs_act, vs_act};
            for (int i = 1; i < PIX_LAT; i++) stage[i] <= stage[i-1];
         end
      end

      assign tap = stage[PIX_LAT-1];
   end

   always_ff @(posedge clock) begin
      if (!reset_n || hold) begin
         vga_r_DAC <= '0;
         vga_g_DAC <= '0;
         vga_b_DAC <= '0;
         vga_hs    <= ~HS_POL;
         vga_vs    <= ~VS_POL;
         vga_blank <= 1'b0;
      end else if (pix_ce) begin
         vga_r_DAC <= tap[2] ? pix_r : '0;
         vga_g_DAC <= tap[2] ? pix_g : '0;
         vga_b_DAC <= tap[2] ? pix_b : '0;
         vga_hs    <= tap[1] ? HS_POL : ~HS_POL;
         vga_vs    <= tap[0] ? VS_POL : ~VS_POL;
         vga_blank <= tap[2];
      end
   end

endmodule

// File: tb/tb_vga_timing_core.sv
// Scoreboard bench for vga_timing_core on a miniature 15x8-tick raster with a
// three-tick pixel source, mixed sync polarities and a divide-by-two pixel tick.
module tb_vga_timing_core;

   localparam int HA = 8, HF = 2, HSY = 3, HB = 2, HT = 15;
   localparam int VA = 4, VF = 1, VSY = 2, VB = 1, VT = 8;
   localparam int DIV = 2, LAT = 3, CW = 10, AW = 6, PERIOD = 10;
   localparam int RUN_TICKS = 3 * HT * VT;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          enable;
   logic [CW-1:0] pix_r, pix_g, pix_b;
   logic [AW-1:0] x_addr, y_addr;
   logic          addr_valid, pix_ce, line_start, frame_start, running;
   logic [CW-1:0] vga_r_DAC, vga_g_DAC, vga_b_DAC;
   logic          vga_hs, vga_vs, vga_blank;

   typedef struct packed {
      logic          blank;
      logic          hs;
      logic          vs;
      logic [CW-1:0] r;
      logic [CW-1:0] g;
      logic [CW-1:0] b;
   } rec_t;

   rec_t          exp_q[$];
   int            errors = 0;
   int            checks = 0;
   logic          ce_seen = 1'b0;
   logic [AW-1:0] x_seen = '0, y_seen = '0;
   bit            scoring = 1'b0;
   int            ce_count = 0, line_count = 0, frame_count = 0;
   time           last_line = 0, last_frame = 0, last_ce = 0;
   logic [CW-1:0] src_r [LAT];
   logic [CW-1:0] src_g [LAT];
   logic [CW-1:0] src_b [LAT];

   vga_timing_core #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
      .HS_POL(1'b0), .VS_POL(1'b1), .CLK_DIV(DIV), .PIX_LAT(LAT),
      .COLOR_W(CW), .CNT_W(AW)
   ) dut (
      .clock(clock), .reset_n(reset_n), .enable(enable),
      .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
      .x_addr(x_addr), .y_addr(y_addr), .addr_valid(addr_valid),
      .pix_ce(pix_ce), .line_start(line_start), .frame_start(frame_start),
      .running(running),
      .vga_r_DAC(vga_r_DAC), .vga_g_DAC(vga_g_DAC), .vga_b_DAC(vga_b_DAC),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank(vga_blank)
   );

   always #(PERIOD/2) clock = ~clock;

   task automatic checkOutput(input string name, input int actual, input int required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, required, $time);
      end
   endtask

   // Blanked output levels with hsync active-low and vsync active-high.
   function automatic rec_t idleRec();
      rec_t e;
      e = '0;
      e.hs = 1'b1;
      e.vs = 1'b0;
      return e;
   endfunction

   function automatic rec_t posRec(input int n);
      rec_t e;
      int   h, v;
      bit   vis;
      h   = n % HT;
      v   = (n / HT) % VT;
      vis = (h < HA) && (v < VA);
      e.blank = vis;
      e.hs    = !((h >= 10) && (h < 13));
      e.vs    = (v >= 5) && (v < 7);
      e.r     = vis ? CW'(h) : '0;
      e.g     = vis ? CW'(v) : '0;
      e.b     = vis ? CW'(h + 16 * v) : '0;
      return e;
   endfunction

   task automatic applyStimulus(input bit en);
      @(negedge clock);
      enable = en;
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_hs"}, int'(vga_hs), 1);
      checkOutput({tag, "_vs"}, int'(vga_vs), 0);
      checkOutput({tag, "_blank"}, int'(vga_blank), 0);
      checkOutput({tag, "_r"}, int'(vga_r_DAC), 0);
      checkOutput({tag, "_x"}, int'(x_addr), 0);
      checkOutput({tag, "_y"}, int'(y_addr), 0);
      checkOutput({tag, "_valid"}, int'(addr_valid), 0);
      checkOutput({tag, "_running"}, int'(running), 0);
      checkOutput({tag, "_pix_ce"}, int'(pix_ce), 0);
   endtask

   task automatic waitLines(input int target, input string name);
      int n = 0;
      while (line_count < target && n < 2000) begin
         @(negedge clock);
         n++;
      end
      checkOutput(name, int'(line_count >= target), 1);
   endtask

   // Capture strobes and addresses mid-cycle, and track line/frame spacing.
   always @(negedge clock) begin
      ce_seen = pix_ce;
      x_seen  = x_addr;
      y_seen  = y_addr;
      if (scoring && line_start) begin
         if (line_count > 0) checkOutput("line_spacing", int'($time - last_line), HT * DIV * PERIOD);
         last_line = $time;
         line_count++;
      end
      if (scoring && frame_start) begin
         if (frame_count > 0) checkOutput("frame_spacing", int'($time - last_frame), HT * VT * DIV * PERIOD);
         checkOutput("frame_start_valid", int'(addr_valid), 1);
         last_frame = $time;
         frame_count++;
      end
   end

   // Pixel source: returns the fetched position LAT ticks later.
   initial forever begin
      @(posedge clock);
      if (ce_seen) begin
         #1;
         for (int i = LAT - 1; i > 0; i--) begin
            src_r[i] = src_r[i-1];
            src_g[i] = src_g[i-1];
            src_b[i] = src_b[i-1];
         end
         src_r[0] = CW'(x_seen);
         src_g[0] = CW'(y_seen);
         src_b[0] = CW'(x_seen) + CW'(y_seen) * 10'd16;
         pix_r = src_r[LAT-1];
         pix_g = src_g[LAT-1];
         pix_b = src_b[LAT-1];
      end
   end

   // Monitor: every pixel tick loads the output registers; pop and compare.
   initial forever begin
      rec_t e;
      @(posedge clock);
      if (ce_seen && scoring) begin
         ce_count++;
         last_ce = $time;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            #1;
            checkOutput("out_blank", int'(vga_blank), int'(e.blank));
            checkOutput("out_hs", int'(vga_hs), int'(e.hs));
            checkOutput("out_vs", int'(vga_vs), int'(e.vs));
            checkOutput("out_r", int'(vga_r_DAC), int'(e.r));
            checkOutput("out_g", int'(vga_g_DAC), int'(e.g));
            checkOutput("out_b", int'(vga_b_DAC), int'(e.b));
         end
      end
   end

   initial begin
      int stray;
      int n;
      reset_n = 1'b0;
      enable  = 1'b0;
      pix_r   = '0;
      pix_g   = '0;
      pix_b   = '0;
      for (int i = 0; i < LAT; i++) begin
         src_r[i] = '0;
         src_g[i] = '0;
         src_b[i] = '0;
      end

      repeat (5) @(posedge clock);
      #1;
      checkIdle("reset");
      @(negedge clock);
      reset_n = 1'b1;
      stray = 0;
      repeat (100) begin
         @(negedge clock);
         if (pix_ce || line_start || frame_start || running) stray++;
      end
      checkOutput("idle_strobes", stray, 0);
      checkIdle("idle");

      // Three frames: drop and re-raise enable inside frame 1, then stop in frame 2.
      for (int i = 0; i < LAT; i++) exp_q.push_back(idleRec());
      for (int p = 0; p < RUN_TICKS - LAT - 1; p++) exp_q.push_back(posRec(p));
      exp_q.push_back(idleRec());
      scoring = 1'b1;
      applyStimulus(1'b1);
      @(posedge clock);
      #1;
      checkOutput("run_entry", int'(running), 1);
      checkOutput("first_tick_wait", int'(pix_ce), 0);

      waitLines(VT + 3, "wait_line_f1v2");
      applyStimulus(1'b0);
      @(posedge clock);
      #1;
      checkOutput("drain_running", int'(running), 1);
      waitLines(VT + 6, "wait_line_f1v5");
      applyStimulus(1'b1);
      waitLines(2 * VT + 3, "wait_line_f2v2");
      applyStimulus(1'b0);

      n = 0;
      while (running && n < 400) begin
         @(negedge clock);
         n++;
      end
      checkOutput("stop_reached", int'(running), 0);
      checkOutput("stop_latency", int'($time - last_ce), PERIOD / 2);
      checkOutput("tick_count", ce_count, RUN_TICKS);
      checkOutput("queue_drained", exp_q.size(), 0);
      checkOutput("frame_count", frame_count, 3);
      checkOutput("line_count", line_count, 3 * VT);
      repeat (20) @(negedge clock);
      checkOutput("idle_after_stop", ce_count, RUN_TICKS);
      checkIdle("stopped");
      scoring = 1'b0;

      // Restart and reset in the middle of an hsync pulse.
      applyStimulus(1'b1);
      n = 0;
      while (vga_hs !== 1'b0 && n < 200) begin
         @(negedge clock);
         n++;
      end
      checkOutput("hsync_seen", int'(vga_hs), 0);
      reset_n = 1'b0;
      enable  = 1'b0;
      @(posedge clock);
      #1;
      checkIdle("midreset");
      @(negedge clock);
      reset_n = 1'b1;
      repeat (4) @(negedge clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
